// File: rtl/bp_lce_req_arbiter.sv
// Round-robin arbiter that merges several LCE request producers onto one
// ready->valid network link. Each producer has a one-entry buffer and an
// outstanding-request credit counter charged at accept time.
module bp_lce_req_arbiter #(
    parameter int unsigned num_req_p   = 2,
    parameter int unsigned msg_width_p = 128,
    parameter int unsigned credits_p   = 8,
    localparam int unsigned SrcW       = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic [num_req_p*msg_width_p-1:0] req_i,
    input  logic [num_req_p-1:0]             req_v_i,
    output logic [num_req_p-1:0]             req_ready_o,
    input  logic [num_req_p-1:0]             credit_return_i,
    output logic [num_req_p-1:0]             credits_full_o,
    output logic                             credits_empty_o,
    output logic [msg_width_p-1:0]           lce_req_o,
    output logic                             lce_req_v_o,
    input  logic                             lce_req_ready_i,
    output logic [SrcW-1:0]                  lce_req_src_o
);

    localparam int unsigned CntW = $clog2(credits_p + 1);

    logic [msg_width_p-1:0] buf_q [num_req_p];
    logic [num_req_p-1:0]   buf_v_q, buf_v_d;
    logic [CntW-1:0]        cnt_q [num_req_p];
    logic [CntW-1:0]        cnt_d [num_req_p];
    logic [SrcW-1:0]        rr_q, rr_d;

    logic [num_req_p-1:0]   grant;
    logic [SrcW-1:0]        grant_idx;
    logic [num_req_p-1:0]   accept;
    logic                   send;

    // Round-robin search starting one past the last granted requester.
    always_comb begin : p_grant
        logic            found;
        logic [SrcW-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = rr_q;
        for (int k = 0; k < int'(num_req_p); k++) begin
            idx = (idx == SrcW'(num_req_p - 1)) ? '0 : idx + 1'b1;
            if (!found && buf_v_q[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                found      = 1'b1;
            end
        end
    end

    // Output link, input handshakes and buffer/pointer next state.
    always_comb begin
        send            = lce_req_ready_i & (|buf_v_q);
        lce_req_v_o     = send;
        lce_req_src_o   = grant_idx;
        lce_req_o       = '0;
        credits_empty_o = 1'b1;
        for (int i = 0; i < int'(num_req_p); i++) begin
            if (grant[i]) lce_req_o = buf_q[i];
            credits_full_o[i] = (cnt_q[i] == CntW'(credits_p));
            if (cnt_q[i] != '0) credits_empty_o = 1'b0;
            // Ready is gated by reset so producers see a quiet link while held in reset.
            req_ready_o[i] = reset_n_i & ~credits_full_o[i]
                           & (~buf_v_q[i] | (grant[i] & lce_req_ready_i));
            accept[i]      = req_ready_o[i] & req_v_i[i];
            buf_v_d[i]     = accept[i] | (buf_v_q[i] & ~(grant[i] & send));
        end
        rr_d = send ? grant_idx : rr_q;
    end

    // Credit counters: simultaneous accept and return cancel; underflow saturates at zero.
    always_comb begin
        for (int i = 0; i < int'(num_req_p); i++) begin
            cnt_d[i] = cnt_q[i];
            if (accept[i] && !credit_return_i[i]) begin
                cnt_d[i] = cnt_q[i] + CntW'(1);
            end else if (!accept[i] && credit_return_i[i] && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - CntW'(1);
            end
        end
    end

    // State registers; reset starts the pointer at the last index so requester 0 wins first.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            buf_v_q <= '0;
            rr_q    <= SrcW'(num_req_p - 1);
            for (int i = 0; i < int'(num_req_p); i++) begin
                buf_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            buf_v_q <= buf_v_d;
            rr_q    <= rr_d;
            for (int i = 0; i < int'(num_req_p); i++) begin
                if (accept[i]) buf_q[i] <= req_i[i*msg_width_p +: msg_width_p];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    for (genvar g = 0; g < int'(num_req_p); g++) begin : g_chk
        // A producer must not raise valid unless ready is already high.
        assert property (@(posedge clk_i) disable iff (!reset_n_i)
                         !(req_v_i[g] && !req_ready_o[g]))
            else $error("requester %0d valid while not ready", g);
        // A credit return with nothing outstanding is a producer bug.
        assert property (@(posedge clk_i) disable iff (!reset_n_i)
                         !(credit_return_i[g] && (cnt_q[g] == '0)))
            else $warning("requester %0d credit return with no outstanding request", g);
    end

endmodule

// File: tb/tb_bp_lce_req_arbiter.sv
// Directed bench for bp_lce_req_arbiter (2 requesters, 128-bit messages, 8 credits).
module tb_bp_lce_req_arbiter;

    logic         clk_i = 1'b0;
    logic         reset_n_i;
    logic [255:0] req_i;
    logic [1:0]   req_v_i;
    logic [1:0]   req_ready_o;
    logic [1:0]   credit_return_i;
    logic [1:0]   credits_full_o;
    logic         credits_empty_o;
    logic [127:0] lce_req_o;
    logic         lce_req_v_o;
    logic         lce_req_ready_i;
    logic [0:0]   lce_req_src_o;

    // Producers normally form valid from ready; raw_v bypasses that during reset only.
    logic         raw_v;
    logic [1:0]   want_v;
    assign req_v_i = raw_v ? want_v : (want_v & req_ready_o);

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    bp_lce_req_arbiter #(
        .num_req_p  (2),
        .msg_width_p(128),
        .credits_p  (8)
    ) dut (
        .clk_i          (clk_i),
        .reset_n_i      (reset_n_i),
        .req_i          (req_i),
        .req_v_i        (req_v_i),
        .req_ready_o    (req_ready_o),
        .credit_return_i(credit_return_i),
        .credits_full_o (credits_full_o),
        .credits_empty_o(credits_empty_o),
        .lce_req_o      (lce_req_o),
        .lce_req_v_o    (lce_req_v_o),
        .lce_req_ready_i(lce_req_ready_i),
        .lce_req_src_o  (lce_req_src_o)
    );

    function automatic logic [127:0] msg_a(input int k);
        return {96'hDEADBEEF_0123_4567_89AB_CDEF, 32'hA000_0000 + 32'(k)};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        reset_n_i       = 1'b0;
        raw_v           = 1'b0;
        want_v          = 2'b00;
        credit_return_i = 2'b00;
        lce_req_ready_i = 1'b0;
        #2;
        @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
    endtask

    localparam logic [127:0] MsgA = 128'hAAAA_0000_1111_2222_3333_4444_5555_6666;
    localparam logic [127:0] MsgB = 128'hBBBB_9999_8888_7777_6666_5555_4444_3333;

    initial begin
        // 1. Reset with both producers forcing valid.
        reset_n_i       = 1'b0;
        raw_v           = 1'b1;
        want_v          = 2'b11;
        credit_return_i = 2'b00;
        lce_req_ready_i = 1'b1;
        req_i           = {MsgB, MsgA};
        #3;
        chk("rst_ready", 128'(req_ready_o), 128'(2'b00));
        chk("rst_v", 128'(lce_req_v_o), 128'(1'b0));
        chk("rst_empty", 128'(credits_empty_o), 128'(1'b1));
        chk("rst_full", 128'(credits_full_o), 128'(2'b00));
        chk("rst_src", 128'(lce_req_src_o), 128'(1'b0));
        next_cycle();
        chk("rst_v_hold", 128'(lce_req_v_o), 128'(1'b0));
        raw_v     = 1'b0;
        want_v    = 2'b00;
        reset_n_i = 1'b1;

        // 2. Fairness: both valid every cycle, link always ready.
        do_reset();
        lce_req_ready_i = 1'b1;
        req_i           = {MsgB, MsgA};
        want_v          = 2'b11;
        #2;
        chk("fair_c0_ready", 128'(req_ready_o), 128'(2'b11));
        chk("fair_c0_v", 128'(lce_req_v_o), 128'(1'b0));
        next_cycle(); #1;
        chk("fair_c1_src", 128'(lce_req_src_o), 128'(1'b0));
        chk("fair_c1_data", lce_req_o, MsgA);
        chk("fair_c1_ready", 128'(req_ready_o), 128'(2'b01));
        next_cycle(); #1;
        chk("fair_c2_src", 128'(lce_req_src_o), 128'(1'b1));
        chk("fair_c2_data", lce_req_o, MsgB);
        chk("fair_c2_ready", 128'(req_ready_o), 128'(2'b10));
        next_cycle(); #1;
        chk("fair_c3_src", 128'(lce_req_src_o), 128'(1'b0));
        chk("fair_c3_v", 128'(lce_req_v_o), 128'(1'b1));
        next_cycle(); #1;
        chk("fair_c4_src", 128'(lce_req_src_o), 128'(1'b1));
        chk("fair_c4_v", 128'(lce_req_v_o), 128'(1'b1));

        // 3. Streaming from requester 0 up to the credit limit.
        do_reset();
        lce_req_ready_i = 1'b1;
        want_v          = 2'b01;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) next_cycle();
            req_i[127:0] = msg_a(k);
            #2;
            if (k > 0) begin
                chk("strm_v", 128'(lce_req_v_o), 128'(1'b1));
                chk("strm_data", lce_req_o, msg_a(k - 1));
            end else begin
                chk("strm_v0", 128'(lce_req_v_o), 128'(1'b0));
            end
            chk("strm_ready", 128'(req_ready_o[0]), 128'(1'b1));
        end
        next_cycle();
        want_v = 2'b00;
        #2;
        chk("strm_last_v", 128'(lce_req_v_o), 128'(1'b1));
        chk("strm_last_data", lce_req_o, msg_a(7));
        chk("strm_full", 128'(credits_full_o), 128'(2'b01));
        chk("strm_full_ready", 128'(req_ready_o[0]), 128'(1'b0));
        next_cycle();
        credit_return_i = 2'b01;
        #2;
        chk("strm_idle_v", 128'(lce_req_v_o), 128'(1'b0));
        chk("strm_ret_ready", 128'(req_ready_o[0]), 128'(1'b0));
        next_cycle();
        credit_return_i = 2'b00;
        #2;
        chk("strm_after_ret_ready", 128'(req_ready_o[0]), 128'(1'b1));
        chk("strm_after_ret_full", 128'(credits_full_o), 128'(2'b00));

        // 4. Backpressure on a buffered requester 1 message.
        do_reset();
        req_i[255:128] = MsgB;
        want_v         = 2'b10;
        #2;
        chk("bp_accept_ready", 128'(req_ready_o[1]), 128'(1'b1));
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            want_v         = 2'b00;
            req_i[255:128] = MsgA;
            #2;
            chk("bp_hold_v", 128'(lce_req_v_o), 128'(1'b0));
            chk("bp_hold_ready", 128'(req_ready_o[1]), 128'(1'b0));
            chk("bp_hold_data", lce_req_o, MsgB);
        end
        next_cycle();
        lce_req_ready_i = 1'b1;
        #2;
        chk("bp_send_v", 128'(lce_req_v_o), 128'(1'b1));
        chk("bp_send_data", lce_req_o, MsgB);
        chk("bp_send_src", 128'(lce_req_src_o), 128'(1'b1));
        for (int k = 0; k < 2; k++) begin
            next_cycle(); #1;
            chk("bp_once_v", 128'(lce_req_v_o), 128'(1'b0));
        end

        // 5a. Accept and return in the same cycle leave the count unchanged.
        do_reset();
        lce_req_ready_i = 1'b1;
        req_i[127:0]    = msg_a(0);
        want_v          = 2'b01;
        next_cycle();
        next_cycle();
        next_cycle();
        credit_return_i = 2'b01;
        #2;
        chk("cred_both_ready", 128'(req_ready_o[0]), 128'(1'b1));
        for (int k = 4; k <= 8; k++) begin
            next_cycle();
            credit_return_i = 2'b00;
            #2;
            chk("cred_not_full", 128'(credits_full_o[0]), 128'(1'b0));
        end
        next_cycle(); #1;
        chk("cred_full", 128'(credits_full_o[0]), 128'(1'b1));
        chk("cred_full_ready", 128'(req_ready_o[0]), 128'(1'b0));

        // 5b. Return with nothing outstanding saturates at zero.
        do_reset();
        credit_return_i = 2'b10;
        #2;
        chk("underflow_pre_empty", 128'(credits_empty_o), 128'(1'b1));
        next_cycle();
        credit_return_i = 2'b00;
        #2;
        chk("underflow_empty", 128'(credits_empty_o), 128'(1'b1));
        chk("underflow_full", 128'(credits_full_o), 128'(2'b00));

        // 6. Asynchronous reset between edges with both buffers full.
        do_reset();
        req_i  = {MsgB, MsgA};
        want_v = 2'b11;
        #2;
        chk("areset_accept", 128'(req_ready_o), 128'(2'b11));
        next_cycle();
        want_v          = 2'b00;
        lce_req_ready_i = 1'b1;
        #1;
        chk("areset_pre_v", 128'(lce_req_v_o), 128'(1'b1));
        chk("areset_pre_empty", 128'(credits_empty_o), 128'(1'b0));
        #1;
        reset_n_i = 1'b0;
        #1;
        chk("areset_v", 128'(lce_req_v_o), 128'(1'b0));
        chk("areset_ready", 128'(req_ready_o), 128'(2'b00));
        chk("areset_empty", 128'(credits_empty_o), 128'(1'b1));
        chk("areset_src", 128'(lce_req_src_o), 128'(1'b0));
        next_cycle();
        reset_n_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            next_cycle(); #1;
            chk("areset_no_stale_v", 128'(lce_req_v_o), 128'(1'b0));
            chk("areset_post_empty", 128'(credits_empty_o), 128'(1'b1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
